// File: rtl/period_meter.sv
// Measures the rise-to-rise spacing of an asynchronous pulse train in CLK cycles.
// A result is handed over with VALID/ACK; a missing rise for MAX_PERIOD cycles raises TIMEOUT.
module period_meter #(
  parameter logic [27:0] MAX_PERIOD = 28'd100_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PULSE_IN,
  input  logic        ACK,
  output logic [27:0] PERIOD,
  output logic        VALID,
  output logic        OVERRUN,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALE   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        s1_r;
  logic        s2_r;
  logic        s3_r;
  logic        rise_s;
  logic [27:0] count_r;
  logic [27:0] count_nxt_s;
  logic [27:0] count_inc_s;
  logic        load_s;
  logic [27:0] period_nxt_s;
  logic        valid_nxt_s;
  logic        overrun_nxt_s;
  logic        timeout_nxt_s;

  assign rise_s      = s2_r & ~s3_r;
  assign count_inc_s = count_r + 28'd1;

  // State, synchronizer and result registers; reset overrides every input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      count_r <= 28'd0;
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      s3_r    <= 1'b0;
      PERIOD  <= 28'd0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      s1_r    <= PULSE_IN;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      PERIOD  <= period_nxt_s;
      VALID   <= valid_nxt_s;
      OVERRUN <= overrun_nxt_s;
      TIMEOUT <= timeout_nxt_s;
    end
  end

  // Next state and count; a rise coinciding with the timeout threshold still counts as a result.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = MEASURE;
          count_nxt_s = 28'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          count_nxt_s = 28'd0;
        end else if (count_inc_s == MAX_PERIOD) begin
          state_nxt_s = STALE;
        end else begin
          count_nxt_s = count_inc_s;
        end
      end
      STALE: begin
        if (rise_s) begin
          state_nxt_s = MEASURE;
          count_nxt_s = 28'd0;
        end else begin
          state_nxt_s = STALE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 28'd0;
      end
    endcase
  end

  // Result handshake; a load racing an ACK keeps OVERRUN as it was.
  always_comb begin
    load_s        = (state_r == MEASURE) & rise_s;
    period_nxt_s  = PERIOD;
    valid_nxt_s   = VALID;
    overrun_nxt_s = OVERRUN;
    timeout_nxt_s = (state_nxt_s == STALE);
    if (load_s) begin
      period_nxt_s = count_inc_s;
      valid_nxt_s  = 1'b1;
      if (VALID && !ACK) begin
        overrun_nxt_s = 1'b1;
      end else begin
        overrun_nxt_s = OVERRUN;
      end
    end else if (ACK) begin
      valid_nxt_s   = 1'b0;
      overrun_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = VALID;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with MAX_PERIOD=16; inputs change and outputs
// are sampled on the falling edge of CLK.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pulse_in = 1'b0;
  logic        ack = 1'b0;
  logic [27:0] period;
  logic        valid;
  logic        overrun;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  period_meter #(.MAX_PERIOD(28'd16)) dut (
    .CLK(clk), .RESET(reset), .PULSE_IN(pulse_in), .ACK(ack),
    .PERIOD(period), .VALID(valid), .OVERRUN(overrun), .TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One-cycle high pulse; the rise is seen by the measuring logic two edges later.
  task automatic pulse();
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pulse_in = 1'b0;
    ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Pulse, then look at the outputs right after the rise has been acted upon (3 cycles used).
  task automatic pulse_check(input string tag, input logic exp_valid, input logic [27:0] exp_period);
    pulse();
    idle(2);
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_valid});
    check({tag, "_period"}, {4'd0, period}, {4'd0, exp_period});
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_period", {4'd0, period}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // Spacing 10 with ACK held high: VALID pulses for one cycle per result.
    ack = 1'b1;
    pulse_check("s10_first", 1'b0, 28'd0);
    idle(7);
    pulse_check("s10_r1", 1'b1, 28'd10);
    step();
    check("s10_r1_drop", {31'd0, valid}, 32'd0);
    idle(6);
    pulse_check("s10_r2", 1'b1, 28'd10);
    step();
    check("s10_r2_drop", {31'd0, valid}, 32'd0);

    // Spacing 5 without ACK: overwrite sets OVERRUN, one ACK clears both flags.
    do_reset();
    pulse_check("s5_first", 1'b0, 28'd0);
    idle(2);
    pulse_check("s5_r1", 1'b1, 28'd5);
    check("s5_r1_ovr", {31'd0, overrun}, 32'd0);
    idle(2);
    pulse_check("s5_r2", 1'b1, 28'd5);
    check("s5_r2_ovr", {31'd0, overrun}, 32'd1);
    idle(2);
    pulse_check("s5_r3", 1'b1, 28'd5);
    check("s5_r3_ovr", {31'd0, overrun}, 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("s5_ack_valid", {31'd0, valid}, 32'd0);
    check("s5_ack_ovr", {31'd0, overrun}, 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("s5_idle_ack_period", {4'd0, period}, 32'd5);
    check("s5_idle_ack_valid", {31'd0, valid}, 32'd0);

    // Single rise then silence: TIMEOUT exactly 16 edges after the acted rise.
    do_reset();
    pulse();
    idle(17);
    check("to_before", {31'd0, timeout}, 32'd0);
    step();
    check("to_assert", {31'd0, timeout}, 32'd1);
    check("to_valid", {31'd0, valid}, 32'd0);
    idle(5);
    check("to_hold", {31'd0, timeout}, 32'd1);
    pulse_check("to_resume", 1'b0, 28'd0);
    idle(4);
    pulse_check("to_s7", 1'b1, 28'd7);

    // Spacing 16 is still a result; spacing 17 times out and yields none.
    do_reset();
    ack = 1'b1;
    pulse_check("b16_first", 1'b0, 28'd0);
    idle(13);
    pulse_check("b16_r", 1'b1, 28'd16);
    idle(14);
    pulse();
    step();
    check("b17_timeout", {31'd0, timeout}, 32'd1);
    step();
    check("b17_timeout_clr", {31'd0, timeout}, 32'd0);
    check("b17_valid", {31'd0, valid}, 32'd0);
    check("b17_period", {4'd0, period}, 32'd16);

    // Reset mid-measurement discards the partial count and the held result.
    do_reset();
    pulse_check("rm_first", 1'b0, 28'd0);
    idle(7);
    pulse_check("rm_pre", 1'b1, 28'd10);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rm_period", {4'd0, period}, 32'd0);
    check("rm_valid", {31'd0, valid}, 32'd0);
    check("rm_overrun", {31'd0, overrun}, 32'd0);
    check("rm_timeout", {31'd0, timeout}, 32'd0);
    pulse_check("rm_after", 1'b0, 28'd0);
    idle(7);
    pulse_check("rm_s10", 1'b1, 28'd10);

    // PULSE_IN already high at release counts as the first rise.
    reset = 1'b1;
    pulse_in = 1'b1;
    ack = 1'b0;
    step();
    reset = 1'b0;
    step();
    pulse_in = 1'b0;
    idle(5);
    pulse_check("hr_s6", 1'b1, 28'd6);

    // Toggling every cycle: minimum period 2, ACK keeps up so no OVERRUN.
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pulse_in = (i % 2 == 0);
      step();
      if (i >= 6) begin
        check("t2_period", {4'd0, period}, 32'd2);
        check("t2_overrun", {31'd0, overrun}, 32'd0);
        check("t2_valid", {31'd0, valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
    end
    pulse_in = 1'b0;
    ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
